instr_loader: RTL and testbench

Boot-time program loader sitting directly upstream of the instruction memory. It accepts a byte stream (length header followed by big-endian 16-bit instruction words) over a valid/ready handshake, assembles words, and drives the memory's write port at sequential addresses starting from 0. While loading it holds the CPU and owns the memory address. When idle it passes the CPU's fetch address straight through to the memory.

---
 rtl/instr_loader_if.sv | 10 +
 rtl/instr_loader.sv | 115 +++++++++++
 tb/tb_instr_loader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream handshake into the instruction loader.
// master = byte source, slave = loader.
interface instr_loader_if;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic       byte_ready;

   modport master (output byte_in, output byte_valid, input  byte_ready);
   modport slave  (input  byte_in, input  byte_valid, output byte_ready);
endinterface

// File: rtl/instr_loader.sv
// Boot-time program loader. Takes a length byte followed by big-endian
// 16-bit words, writes them to instruction memory from address 0 and
// holds the CPU meanwhile. When idle, the CPU fetch address is passed
// straight through to the memory.
module instr_loader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   instr_loader_if.slave     stream,
   input  logic [ADDR_W-1:0] pc_add,
   output logic [DATA_W-1:0] instruction_in,
   output logic [ADDR_W-1:0] instruction_add,
   output logic              write_enable,
   output logic              cpu_hold,
   output logic              load_done,
   output logic [ADDR_W:0]   words_loaded
);

   // A length byte of 0 stands for a full memory image.
   localparam logic [ADDR_W:0] FULL_LEN = (ADDR_W+1)'(1) << ADDR_W;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEN  = 3'd1,
      HI   = 3'd2,
      LO   = 3'd3,
      WR   = 3'd4,
      DONE = 3'd5
   } state_t;

   state_t            state, state_nxt;
   logic              byte_ready;
   logic              accept;
   logic [ADDR_W-1:0] load_addr;
   logic [ADDR_W:0]   remaining;
   logic [7:0]        hi_byte;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and stream ready; the loader only listens in LEN/HI/LO.
   always_comb begin
      state_nxt  = state;
      byte_ready = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = LEN;
         LEN: begin
            byte_ready = 1'b1;
            if (stream.byte_valid) state_nxt = HI;
         end
         HI: begin
            byte_ready = 1'b1;
            if (stream.byte_valid) state_nxt = LO;
         end
         LO: begin
            byte_ready = 1'b1;
            if (stream.byte_valid) state_nxt = WR;
         end
         WR:      state_nxt = (remaining == (ADDR_W+1)'(1)) ? DONE : HI;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign accept            = byte_ready && stream.byte_valid;
   assign stream.byte_ready = byte_ready;

   // Datapath: length counter, word assembly, write strobe, addressing.
   // write_enable is only set from LO so it is high for exactly the WR
   // cycle, during which load_addr still holds the target address.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         load_addr      <= '0;
         words_loaded   <= '0;
         remaining      <= '0;
         hi_byte        <= '0;
         instruction_in <= '0;
         write_enable   <= 1'b0;
      end else begin
         write_enable <= 1'b0;
         case (state)
            IDLE: if (start) begin
               load_addr    <= '0;
               words_loaded <= '0;
            end
            LEN: if (accept)
               remaining <= (stream.byte_in == 8'd0) ? FULL_LEN
                                                     : (ADDR_W+1)'(stream.byte_in);
            HI: if (accept) hi_byte <= stream.byte_in;
            LO: if (accept) begin
               instruction_in <= {hi_byte, stream.byte_in};
               write_enable   <= 1'b1;
            end
            WR: begin
               load_addr    <= load_addr + ADDR_W'(1);
               words_loaded <= words_loaded + (ADDR_W+1)'(1);
               remaining    <= remaining - (ADDR_W+1)'(1);
            end
            default: ;
         endcase
      end
   end

   // Status decode and memory address ownership.
   assign cpu_hold        = (state != IDLE);
   assign load_done       = (state == DONE);
   assign instruction_add = cpu_hold ? load_addr : pc_add;

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: idle pass-through vectors, directed loads and
// randomized loads checked against a write list derived from the stream.
module tb_instr_loader;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [7:0]  pc_add = 8'h5A;
   logic [15:0] instruction_in;
   logic [7:0]  instruction_add;
   logic        write_enable, cpu_hold, load_done;
   logic [8:0]  words_loaded;

   instr_loader_if sif();

   instr_loader dut (
      .clk(clk), .reset(reset), .start(start), .stream(sif.slave),
      .pc_add(pc_add), .instruction_in(instruction_in),
      .instruction_add(instruction_add), .write_enable(write_enable),
      .cpu_hold(cpu_hold), .load_done(load_done), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   typedef struct { logic [7:0] addr; logic [15:0] data; } wr_t;
   typedef struct { logic [7:0] pc; logic bv; logic [7:0] bin;
                    logic [7:0] exp_add; logic exp_rdy; logic exp_hold; } vec_t;

   int          errors = 0, checks = 0;
   int          cyc = 0, start_cyc = 0, done_edge = 0, done_cnt = 0, rdy_in_wr = 0;
   wr_t         wr_q[$];
   logic [15:0] mem [256];

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model and event monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (write_enable) begin
         wr_q.push_back('{addr: instruction_add, data: instruction_in});
         mem[instruction_add] = instruction_in;
         if (sif.byte_ready) rdy_in_wr++;
      end
      if (load_done) begin
         done_cnt++;
         done_edge = cyc + 1;
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_start();
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0; start_cyc = cyc;
   endtask

   // Offer one byte and wait (bounded) for it to be taken.
   task automatic push(input logic [7:0] b);
      int t = 0;
      sif.byte_valid = 1'b1; sif.byte_in = b;
      forever begin
         @(negedge clk);
         if (sif.byte_ready) break;
         if (++t > 50) begin chk("push_timeout", 1, 0); break; end
      end
      @(posedge clk); #1;
      sif.byte_valid = 1'b0; sif.byte_in = $urandom_range(0, 255);
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while (cpu_hold) begin
         @(negedge clk);
         if (++t > 100) begin chk({tag, ".idle_timeout"}, 1, 0); break; end
      end
   endtask

   // Reference: a stream is len (0 => 256) then len big-endian words,
   // word i lands at address i mod 256.
   task automatic ref_model(input logic [7:0] bs[$], output int n, output logic [15:0] w[$]);
      n = (bs[0] == 8'd0) ? 256 : int'(bs[0]);
      w.delete();
      for (int i = 0; i < n; i++) w.push_back({bs[1+2*i], bs[2+2*i]});
   endtask

   // gap < 0: random 0..3 idle cycles after each byte.
   // pulse >= 0: pulse start after that byte index has been accepted.
   task automatic run_load(input logic [7:0] bs[$], input int gap, input int pulse, input string tag);
      int n, bad, g;
      logic [15:0] w[$];
      wr_q.delete(); done_cnt = 0; rdy_in_wr = 0;
      do_start();
      foreach (bs[i]) begin
         push(bs[i]);
         if (i == pulse) begin start = 1'b1; @(posedge clk); #1; start = 1'b0; end
         g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
         repeat (g) begin @(posedge clk); #1; end
      end
      wait_idle(tag);
      repeat (2) @(negedge clk);
      ref_model(bs, n, w);
      chk({tag, ".nwr"}, wr_q.size(), n);
      bad = 0;
      for (int i = 0; i < n && i < wr_q.size(); i++)
         if (wr_q[i].addr !== 8'(i % 256) || wr_q[i].data !== w[i]) begin
            if (bad == 0) $display("  %s first bad write %0d: add %0h data %0h", tag, i, wr_q[i].addr, wr_q[i].data);
            bad++;
         end
      chk({tag, ".wrseq_bad"}, bad, 0);
      bad = 0;
      for (int i = 0; i < n; i++) if (mem[i % 256] !== w[i]) bad++;
      chk({tag, ".mem_bad"}, bad, 0);
      chk({tag, ".words_loaded"}, words_loaded, n);
      chk({tag, ".done_pulses"}, done_cnt, 1);
      chk({tag, ".instr_in_last"}, instruction_in, w[n-1]);
      chk({tag, ".rdy_in_wr"}, rdy_in_wr, 0);
      if (gap == 0 && pulse < 0) chk({tag, ".done_latency"}, done_edge - start_cyc, 2 + 3*n);
   endtask

   initial begin
      vec_t        vt[6];
      logic [7:0]  bs[$];
      logic [7:0]  p;
      int          n;

      sif.byte_valid = 1'b0; sif.byte_in = 8'h00;

      // Reset state.
      #3;
      chk("rst.byte_ready", sif.byte_ready, 0);
      chk("rst.write_enable", write_enable, 0);
      chk("rst.instruction_in", instruction_in, 0);
      chk("rst.instruction_add", instruction_add, 8'h5A);
      chk("rst.words_loaded", words_loaded, 0);
      chk("rst.cpu_hold", cpu_hold, 0);
      chk("rst.load_done", load_done, 0);
      @(posedge clk); #1; reset = 1'b0;

      // Idle vectors: address pass-through, valid bytes never accepted.
      vt[0] = '{8'h00, 1'b0, 8'h11, 8'h00, 1'b0, 1'b0};
      vt[1] = '{8'h5A, 1'b1, 8'h02, 8'h5A, 1'b0, 1'b0};
      vt[2] = '{8'hFF, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b0};
      vt[3] = '{8'h80, 1'b0, 8'hAA, 8'h80, 1'b0, 1'b0};
      vt[4] = '{8'h13, 1'b1, 8'h77, 8'h13, 1'b0, 1'b0};
      vt[5] = '{8'hC3, 1'b1, 8'h01, 8'hC3, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         pc_add = vt[i].pc; sif.byte_valid = vt[i].bv; sif.byte_in = vt[i].bin;
         @(negedge clk);
         chk($sformatf("vec%0d.add", i), instruction_add, vt[i].exp_add);
         chk($sformatf("vec%0d.rdy", i), sif.byte_ready, vt[i].exp_rdy);
         chk($sformatf("vec%0d.hold", i), cpu_hold, vt[i].exp_hold);
         @(posedge clk); #1;
      end
      sif.byte_valid = 1'b0;
      chk("idle.no_writes", wr_q.size(), 0);

      // Basic back-to-back load.
      bs = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      run_load(bs, 0, -1, "basic");

      // Asynchronous reset between edges clears everything at once.
      pc_add = 8'h5A;
      @(posedge clk); #2; reset = 1'b1; #1;
      chk("arst.instruction_in", instruction_in, 0);
      chk("arst.words_loaded", words_loaded, 0);
      chk("arst.instruction_add", instruction_add, 8'h5A);
      chk("arst.cpu_hold", cpu_hold, 0);
      @(posedge clk); #1; reset = 1'b0;

      // Stalled stream: three idle cycles after every byte.
      run_load(bs, 3, -1, "stall");

      // start pulsed while in HI is ignored.
      run_load(bs, 0, 0, "start_in_hi");

      // Reset after the third word's HI byte.
      bs = '{8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      wr_q.delete();
      do_start();
      foreach (bs[i]) push(bs[i]);
      #1; reset = 1'b1; #1;
      chk("midrst.cpu_hold", cpu_hold, 0);
      chk("midrst.write_enable", write_enable, 0);
      chk("midrst.instruction_add", instruction_add, pc_add);
      repeat (3) @(posedge clk); #1; reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst.nwr", wr_q.size(), 2);
      chk("midrst.words_loaded", words_loaded, 0);

      // Randomized loads, including the one right after the aborted load.
      for (int r = 0; r < 4; r++) begin
         bs.delete();
         n = $urandom_range(1, 12);
         bs.push_back(8'(n));
         for (int i = 0; i < 2*n; i++) bs.push_back(8'($urandom_range(0, 255)));
         run_load(bs, -1, -1, $sformatf("rand%0d", r));
      end

      // After a load the fetch address passes straight through each cycle.
      for (int i = 0; i < 6; i++) begin
         p = 8'($urandom_range(0, 255));
         @(posedge clk); #1; pc_add = p;
         @(negedge clk);
         chk($sformatf("post.add%0d", i), instruction_add, p);
      end

      // Full 256-word load (length byte 0).
      bs.delete();
      bs.push_back(8'h00);
      for (int i = 0; i < 512; i++) bs.push_back(8'($urandom_range(0, 255)));
      run_load(bs, 0, -1, "full");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
